// File: rtl/tile_map_pkg.sv
// Shared constants and types for the tile map scheduler.
// Tile codes, map geometry and FSM state encoding.
package tile_map_pkg;

   localparam int CELLS  = 100;
   localparam int ADDR_W = 7;
   localparam int TILE_W = 3;

   localparam logic [TILE_W-1:0] TILE_BG    = 3'd0;
   localparam logic [TILE_W-1:0] TILE_BLOCK = 3'd1;
   localparam logic [TILE_W-1:0] TILE_P1    = 3'd2;
   localparam logic [TILE_W-1:0] TILE_P2    = 3'd3;
   localparam logic [TILE_W-1:0] TILE_BOMB0 = 3'd4;
   localparam logic [TILE_W-1:0] TILE_BOMB1 = 3'd5;
   localparam logic [TILE_W-1:0] TILE_BOMB2 = 3'd6;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_ARB    = 2'd1,
      ST_CLEAR  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker for the tile write port.
// Grants the first request at or after ptr_i; caller registers.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   ptr_o
);

   logic             found;
   logic [PTR_W-1:0] idx;

   // scan from the pointer, wrapping, and take the first request
   always_comb begin
      gnt_o = '0;
      ptr_o = ptr_i;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((32'(ptr_i) + 32'(k)) % NUM_REQ);
         if (en_i && !found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            ptr_o      = PTR_W'((32'(idx) + 1) % NUM_REQ);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_map_sched.sv
// Tile map owner: blanking-only writes, round-robin requesters,
// sequenced full-map clear and a registered renderer read port.
module tile_map_sched
   import tile_map_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int CELLS   = tile_map_pkg::CELLS,
   parameter int TILE_W  = tile_map_pkg::TILE_W,
   parameter int ADDR_W  = tile_map_pkg::ADDR_W
) (
   input  logic                      pixel_clk,
   input  logic                      rst,
   input  logic                      vblank,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
   input  logic [NUM_REQ*TILE_W-1:0] wr_data,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic                      clear_req,
   output logic                      busy,
   output logic                      addr_err,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [TILE_W-1:0]         rd_data,
   output logic [7:0]                frame_cnt
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state_q, state_d;
   logic [TILE_W-1:0]   mem_q [CELLS];
   logic [NUM_REQ-1:0]  gnt_q, pick;
   logic [PTR_W-1:0]    rr_q, rr_d;
   logic [ADDR_W-1:0]   clr_q, clr_d;
   logic                pend_q, pend_d;
   logic                err_q, err_d;
   logic [TILE_W-1:0]   rd_q, rd_d;
   logic                vb_q;
   logic [7:0]          frm_q, frm_d;
   logic                arb_en, clr_on, clr_done;
   logic [ADDR_W-1:0]   sel_addr;
   logic [TILE_W-1:0]   sel_data;
   logic                sel_ok;

   assign arb_en   = (state_q == ST_ARB) && !pend_q;
   assign clr_on   = (state_q == ST_CLEAR);
   assign clr_done = clr_on && (int'(clr_q) == CELLS - 1);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req_i (req & ~gnt_q),
      .ptr_i (rr_q),
      .en_i  (arb_en),
      .gnt_o (pick),
      .ptr_o (rr_d)
   );

   // route the winning requester's address and data
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
            sel_data = wr_data[i*TILE_W +: TILE_W];
         end
      end
   end

   assign sel_ok = int'(sel_addr) < CELLS;

   // next state: blanking tracking, clear sweep and pointers
   always_comb begin
      err_d  = (|pick) && !sel_ok;
      clr_d  = clr_q;
      pend_d = pend_q | clear_req;
      if (clr_on) begin
         clr_d = clr_done ? '0 : clr_q + 1'b1;
      end
      if (clr_done) begin
         pend_d = 1'b0;
      end
      if (!vblank) begin
         state_d = ST_ACTIVE;
      end else if (clr_on) begin
         state_d = clr_done ? ST_ARB : ST_CLEAR;
      end else begin
         state_d = pend_q ? ST_CLEAR : ST_ARB;
      end
      rd_d  = (int'(rd_addr) < CELLS) ? mem_q[rd_addr] : '0;
      frm_d = (vblank && !vb_q) ? frm_q + 8'd1 : frm_q;
   end

   // control and output registers
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ACTIVE;
         gnt_q   <= '0;
         rr_q    <= '0;
         clr_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         vb_q    <= 1'b0;
         frm_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= pick;
         rr_q    <= rr_d;
         clr_q   <= clr_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         vb_q    <= vblank;
         frm_q   <= frm_d;
      end
   end

   // tile storage: sweep zeroes take precedence over grants
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CELLS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_on) begin
         mem_q[clr_q] <= TILE_W'(TILE_BG);
      end else if ((|pick) && sel_ok) begin
         mem_q[sel_addr] <= sel_data;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = pend_q;
   assign addr_err  = err_q;
   assign rd_data   = rd_q;
   assign frame_cnt = frm_q;

endmodule

// File: tb/tb_tile_map_sched.sv
// Bench for tile_map_sched: directed scenarios plus random
// traffic, all compared against a behavioural map model.
module tb_tile_map_sched;

   localparam int NR    = 3;
   localparam int CELLS = 100;
   localparam int AW    = 7;
   localparam int TW    = 3;

   logic              pixel_clk = 1'b0;
   logic              rst = 1'b0;
   logic              vblank = 1'b0;
   logic              clear_req = 1'b0;
   logic [NR-1:0]     req;
   logic [NR*AW-1:0]  wr_addr;
   logic [NR*TW-1:0]  wr_data;
   logic [NR-1:0]     gnt;
   logic              busy;
   logic              addr_err;
   logic [AW-1:0]     rd_addr = '0;
   logic [TW-1:0]     rd_data;
   logic [7:0]        frame_cnt;

   int n_checks = 0;
   int n_errors = 0;

   bit rq [NR];
   int ra [NR];
   int rdat [NR];

   int        m_mem [CELLS];
   bit        m_vb_prev, m_sweep, m_pend, m_err;
   int        m_ptr, m_rr, m_rd, m_frame;
   bit [NR-1:0] m_gnt;

   tile_map_sched #(.NUM_REQ(NR)) dut (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .vblank    (vblank),
      .req       (req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .gnt       (gnt),
      .clear_req (clear_req),
      .busy      (busy),
      .addr_err  (addr_err),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .frame_cnt (frame_cnt)
   );

   always #20 pixel_clk = ~pixel_clk;

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req[i]               = rq[i];
         wr_addr[i*AW +: AW]  = AW'(ra[i]);
         wr_data[i*TW +: TW]  = TW'(rdat[i]);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CELLS; c++) m_mem[c] = 0;
      m_vb_prev = 0; m_sweep = 0; m_pend = 0; m_err = 0;
      m_ptr = 0; m_rr = 0; m_rd = 0; m_frame = 0;
      m_gnt = '0;
   endtask

   // what the map does at one clock edge, given the
   // blanking seen at the previous edge
   task automatic model_step();
      int rdv;
      int i;
      bit done;
      bit e;
      bit [NR-1:0] g;
      rdv  = (int'(rd_addr) < CELLS) ? m_mem[rd_addr] : 0;
      done = 0; e = 0; g = '0;
      if (m_vb_prev && m_sweep) begin
         m_mem[m_ptr] = 0;
         done  = (m_ptr == CELLS - 1);
         m_ptr = (m_ptr + 1) % CELLS;
      end else if (m_vb_prev && !m_pend) begin
         for (int k = 0; k < NR; k++) begin
            i = (m_rr + k) % NR;
            if (g == '0 && rq[i] && !m_gnt[i]) begin
               g[i] = 1'b1;
               m_rr = (i + 1) % NR;
               if (ra[i] < CELLS) m_mem[ra[i]] = rdat[i];
               else e = 1'b1;
            end
         end
      end
      m_sweep = vblank && (m_sweep ? !done : m_pend);
      m_pend  = done ? 1'b0 : (m_pend | clear_req);
      if (vblank && !m_vb_prev) m_frame = (m_frame + 1) % 256;
      m_vb_prev = vblank;
      m_gnt = g;
      m_err = e;
      m_rd  = rdv;
   endtask

   task automatic cycle();
      drive();
      @(posedge pixel_clk);
      model_step();
      @(negedge pixel_clk);
      chk("gnt", gnt, m_gnt);
      chk("busy", busy, m_pend);
      chk("addr_err", addr_err, m_err);
      chk("rd_data", rd_data, m_rd);
      chk("frame_cnt", frame_cnt, m_frame);
      clear_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vblank = 1'b0;
      clear_req = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rq[i] = 0; ra[i] = 0; rdat[i] = 0;
      end
      drive();
      model_reset();
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      @(negedge pixel_clk);
      rst = 1'b0;
   endtask

   task automatic wait_gnt(input int i);
      int t;
      t = 0;
      do begin
         cycle();
         t++;
      end while (!m_gnt[i] && t < 20);
      chk("gnt_wait", gnt[i], 1);
   endtask

   task automatic new_wr(input int i);
      ra[i]   = $urandom_range(0, 104);
      rdat[i] = $urandom_range(0, 7);
   endtask

   initial begin
      int n0, ngr, exp_i, t, vb_left;
      #5;

      // writes held off during active video
      do_reset();
      rq[0] = 1; ra[0] = 5; rdat[0] = 2;
      rd_addr = 7'd5;
      n0 = 0;
      repeat (50) begin
         cycle();
         if (gnt[0]) n0++;
      end
      chk("t1_no_gnt_active", n0, 0);
      vblank = 1'b1;
      repeat (20) begin
         cycle();
         if (gnt[0]) n0++;
         if (m_gnt[0]) rq[0] = 0;
      end
      chk("t1_one_gnt", n0, 1);
      chk("t1_rd5", rd_data, 2);

      // round robin with all three requesters
      do_reset();
      vblank = 1'b1;
      for (int i = 0; i < NR; i++) begin
         rq[i] = 1; ra[i] = i; rdat[i] = i + 2;
      end
      exp_i = 0;
      ngr = 0;
      repeat (40) begin
         cycle();
         chk("t2_onehot", $countones(gnt) <= 1, 1);
         for (int i = 0; i < NR; i++) begin
            if (gnt[i]) begin
               chk("t2_order", i, exp_i);
               exp_i = (exp_i + 1) % NR;
               ngr++;
            end
         end
      end
      chk("t2_grant_rate", ngr > 30, 1);
      for (int i = 0; i < NR; i++) rq[i] = 0;

      // fill with blocks, then a clear cut short by video
      for (int c = 0; c < CELLS; c++) begin
         rq[0] = 1; ra[0] = c; rdat[0] = 1;
         wait_gnt(0);
      end
      rq[0] = 0;
      vblank = 1'b0;
      repeat (3) cycle();
      clear_req = 1'b1;
      cycle();
      chk("t3_busy_rise", busy, 1);
      vblank = 1'b1;
      repeat (38) cycle();
      vblank = 1'b0;
      repeat (5) cycle();
      for (int c = 0; c < CELLS; c++) begin
         rd_addr = AW'(c);
         cycle();
         chk("t3_partial", rd_data, (c < 38) ? 0 : 1);
      end
      chk("t3_busy_held", busy, 1);
      vblank = 1'b1;
      t = 0;
      do begin
         cycle();
         t++;
      end while (m_pend && t < 300);
      chk("t3_busy_drop", busy, 0);
      vblank = 1'b0;
      for (int c = 0; c < CELLS; c++) begin
         rd_addr = AW'(c);
         cycle();
         chk("t3_cleared", rd_data, 0);
      end

      // out-of-range write address
      vblank = 1'b1;
      rq[1] = 1; ra[1] = 100; rdat[1] = 5;
      wait_gnt(1);
      chk("t4_err_with_gnt", addr_err, 1);
      rq[1] = 0;
      vblank = 1'b0;
      for (int c = 0; c <= CELLS; c++) begin
         rd_addr = AW'(c);
         cycle();
         chk("t4_unchanged", rd_data, 0);
      end

      // reset in the middle of a sweep
      vblank = 1'b1;
      for (int c = 60; c < CELLS; c++) begin
         rq[2] = 1; ra[2] = c; rdat[2] = 6;
         wait_gnt(2);
      end
      rq[2] = 0;
      clear_req = 1'b1;
      t = 0;
      do begin
         cycle();
         t++;
      end while (m_ptr != 60 && t < 300);
      chk("t5_reached_60", m_ptr, 60);
      do_reset();
      for (int c = 0; c < CELLS; c++) begin
         rd_addr = AW'(c);
         cycle();
         chk("t5_zero", rd_data, 0);
      end

      // frame counter wrap
      for (int k = 0; k < 256; k++) begin
         vblank = 1'b1;
         cycle();
         vblank = 1'b0;
         cycle();
         if (k == 254) chk("t6_255", frame_cnt, 255);
      end
      chk("t6_wrap", frame_cnt, 0);

      // random traffic
      do_reset();
      vb_left = 0;
      repeat (3000) begin
         if (vb_left == 0) begin
            vblank = !vblank;
            vb_left = vblank ? $urandom_range(3, 150)
                             : $urandom_range(5, 60);
         end
         vb_left--;
         if ($urandom_range(0, 59) == 0) clear_req = 1'b1;
         rd_addr = AW'($urandom_range(0, 110));
         cycle();
         for (int i = 0; i < NR; i++) begin
            if (rq[i] && m_gnt[i]) begin
               if ($urandom_range(0, 1) == 1) new_wr(i);
               else rq[i] = 0;
            end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
               rq[i] = 1;
               new_wr(i);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
